// File: rtl/rv32i_packet_pipe_buffer.sv
// Elastic valid/ready buffer carrying one RV32I data packet and one control packet between stages.
// Optional performance counters are built when PKT_PIPE_PERF_EN is defined; otherwise the ports read zero.
module rv32i_packet_pipe_buffer #(
    parameter int                  DATA_W   = 160,
    parameter int                  CTRL_W   = 192,
    parameter int                  DEPTH    = 2,
    parameter logic [CTRL_W-1:0]   NOP_CTRL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt,
    output logic [31:0]                  flush_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [CTRL_W-1:0] mem_ctrl [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // in_ready depends only on registered occupancy plus rst/flush, never on out_ready.
    assign in_ready  = (count_q != CNT_FULL) && !rst && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; the output mux hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= in_data;
            mem_ctrl[wr_ptr_q] <= in_ctrl;
        end
    end

    always_comb begin
        out_data = '0;
        out_ctrl = NOP_CTRL;
        if (out_valid) begin
            out_data = mem_data[rd_ptr_q];
            out_ctrl = mem_ctrl[rd_ptr_q];
        end
    end

`ifdef PKT_PIPE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counters; reset is the only way to clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign stall_cnt  = 32'h0;
    assign bubble_cnt = 32'h0;
    assign flush_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_rv32i_packet_pipe_buffer.sv
// Directed self-checking bench for rv32i_packet_pipe_buffer (DEPTH=2).
// Perf-counter expectations follow PKT_PIPE_PERF_EN the same way the design does.
module tb_rv32i_packet_pipe_buffer;

    localparam int DATA_W = 160;
    localparam int CTRL_W = 192;
    localparam int DEPTH  = 2;
    localparam logic [CTRL_W-1:0] NOP = '0;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        count;
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
    logic [31:0]       flush_cnt;

    int checks = 0;
    int errors = 0;

    rv32i_packet_pipe_buffer #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .DEPTH   (DEPTH),
        .NOP_CTRL(NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .count     (count),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // pc sits in the top word; other words are derived so every field is distinct.
    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] pc);
        return {pc, ~pc, pc + 32'd4, pc ^ 32'h0000_00FF, 32'hC0DE_0000 | pc};
    endfunction

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [31:0] pc);
        return {pc, 32'h1, 32'h2, 32'h3, 32'h4, ~pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_data  = mk_data(pc);
        in_ctrl  = mk_ctrl(pc);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 32'h0);
        tick();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (out_ctrl !== NOP) begin errors++; $display("FAIL reset_out_ctrl: got %0h want %0h", out_ctrl, NOP); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h60; pcs[1] = 32'h64; pcs[2] = 32'h68;
        out_ready = 1'b1;
        drive(1'b1, pcs[0]);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: got out_valid %0b want 0", out_valid); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive(1'b1, pcs[i]); else drive(1'b0, 32'h0);
            #1;
            checks++; if (out_data !== mk_data(pcs[i-1])) begin errors++; $display("FAIL stream_data_%0d: got %0h want %0h", i, out_data, mk_data(pcs[i-1])); end
            checks++; if (out_ctrl !== mk_ctrl(pcs[i-1])) begin errors++; $display("FAIL stream_ctrl_%0d: got %0h want %0h", i, out_ctrl, mk_ctrl(pcs[i-1])); end
            checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ_%0d: got count %0d ready %0b want 1 1", i, count, in_ready); end
            tick();
        end
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got count %0d valid %0b want 0 0", count, out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h100);
        tick();
        drive(1'b1, 32'h104);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready: got %0b want 1", in_ready); end
        tick();
        drive(1'b1, 32'h108);
        #1;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count_full: got %0d want 2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %0b want 0", in_ready); end
        checks++; if (out_data !== mk_data(32'h100)) begin errors++; $display("FAIL bp_head: got %0h want %0h", out_data, mk_data(32'h100)); end
        tick();
        drive(1'b0, 32'h0);
        checks++; if (count !== 2'd2 || out_data !== mk_data(32'h100)) begin errors++; $display("FAIL bp_hold: got count %0d data %0h want 2 %0h", count, out_data, mk_data(32'h100)); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== mk_data(32'h104) || count !== 2'd1) begin errors++; $display("FAIL bp_second_pop: got count %0d data %0h want 1 %0h", count, out_data, mk_data(32'h104)); end
        tick();
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got count %0d valid %0b want 0 0", count, out_valid); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        drive(1'b1, 32'hA0);
        tick();
        drive(1'b1, 32'hA4);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 32'hA8);
        #1;
        checks++; if (in_ready !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL full_pop_ready: got ready %0b count %0d want 0 2", in_ready, count); end
        tick();
        checks++; if (count !== 2'd1 || out_data !== mk_data(32'hA4)) begin errors++; $display("FAIL full_pop_after: got count %0d data %0h want 1 %0h", count, out_data, mk_data(32'hA4)); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready_back: got %0b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0);
        checks++; if (count !== 2'd1 || out_data !== mk_data(32'hA8) || out_ctrl !== mk_ctrl(32'hA8)) begin
            errors++; $display("FAIL full_pop_wrap: got count %0d data %0h want 1 %0h", count, out_data, mk_data(32'hA8));
        end
        tick();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL full_pop_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hB0);
        tick();
        drive(1'b1, 32'hB4);
        tick();
        drive(1'b1, 32'hB8);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== mk_data(32'hB0)) begin errors++; $display("FAIL flush_cycle_head: got valid %0b data %0h want 1 %0h", out_valid, out_data, mk_data(32'hB0)); end
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got count %0d valid %0b want 0 0", count, out_valid); end
        checks++; if (out_ctrl !== NOP || out_data !== '0) begin errors++; $display("FAIL flush_bubble: got ctrl %0h data %0h want %0h 0", out_ctrl, out_data, NOP); end
        // Partially filled: the incoming packet would be accepted but for the flush.
        out_ready = 1'b0;
        drive(1'b1, 32'hC0);
        tick();
        drive(1'b1, 32'hC4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 32'h200);
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL flush_drop_push: got count %0d want 0", count); end
        tick();
        drive(1'b0, 32'h0);
        checks++; if (count !== 2'd1 || out_data !== mk_data(32'h200)) begin errors++; $display("FAIL flush_refill: got count %0d data %0h want 1 %0h", count, out_data, mk_data(32'h200)); end
        // Reset mid-operation discards the buffered entry.
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %0b want 0", in_ready); end
        tick();
        rst = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_empty: got count %0d valid %0b want 0 0", count, out_valid); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall, exp_bubble, exp_flush;
`ifdef PKT_PIPE_PERF_EN
        exp_stall = 32'd3; exp_bubble = 32'd4; exp_flush = 32'd2;
`else
        exp_stall = 32'd0; exp_bubble = 32'd0; exp_flush = 32'd0;
`endif
        rst = 1'b1; out_ready = 1'b0; drive(1'b0, 32'h0);
        tick();
        rst = 1'b0;
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        tick();
        drive(1'b1, 32'h300);
        tick();
        drive(1'b0, 32'h0);
        tick();
        tick();
        tick();
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, exp_stall); end
        checks++; if (bubble_cnt !== exp_bubble) begin errors++; $display("FAIL perf_bubble: got %0d want %0d", bubble_cnt, exp_bubble); end
        checks++; if (flush_cnt !== exp_flush) begin errors++; $display("FAIL perf_flush: got %0d want %0d", flush_cnt, exp_flush); end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
